mc_irq_ctrl: RTL
================

# mc_irq_ctrl

Parametrised interrupt controller for the multi-cycle CPU. It replaces the single INT/NMI flag pair latched inside the control FSM with:

- N edge-latched maskable lines with fixed priority;
- one non-maskable line;
- vector generation;
- in-service tracking.

It sits beside the control unit, presents one request at a time, and the control FSM accepts it at an instruction boundary (fetch state) with a req/ack handshake.

## Interface
- NUM_IRQ, 8: maskable lines, 1..32; index 0 = highest priority
- VEC_W, 32: vector/PC width
- VEC_BASE, 32'h0000_0100: vector of line 0
- VEC_STRIDE, 4: byte spacing between line vectors
- NMI_VEC, 32'h0000_0080: NMI vector

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- irq_i  in  NUM_IRQ  maskable lines, rising-edge sensitive, synchronous to clk
- nmi_i  in  1  non-maskable line, rising-edge sensitive
- gie_i  in  1  global enable for maskable lines (CPU status bit)
- mask_we_i  in  1  write enable for the mask register
- mask_wdata_i  in  NUM_IRQ  new mask; 1 = enabled
- req_o  out  1  request to control FSM
- req_nmi_o  out  1  the current request is the NMI
- vector_o  out  VEC_W  target PC for the current request
- id_o  out  $clog2(NUM_IRQ)  line index of a maskable request; 0 for NMI
- ack_i  in  1  control FSM entered the interrupt state
- eret_i  in  1  return-from-interrupt executed
- pending_o  out  NUM_IRQ  pending register
- in_service_o  out  NUM_IRQ  in-service register
- mask_o  out  NUM_IRQ  mask register

## Operation
- **Edge detection:** irq_i and nmi_i are registered once (prev_*). A rising edge sets the corresponding pending bit (or nmi_pend) at that clock edge.
- **Set/clear collisions:** if a set and a clear of the same bit happen in one cycle, set wins.
- **Mask:** written on mask_we_i. Pending bits latch regardless of mask; masked bits are only ineligible.
- **Eligible maskable line:** pending & mask & gie_i, with priority strictly higher than the highest in-service line (see Configuration).
- **Eligible NMI:** nmi_pend & ~nmi_active.
- **NMI precedence:** NMI wins over any maskable line.
- **FSM states:**
  - IDLE → REQ when any request is eligible; the winner is captured into req_nmi/id/vector registers.
  - REQ: req_o = 1. Outputs are frozen until ack_i, even if a higher-priority line arrives or the mask, gie_i or an eret_i change.
  - REQ → IDLE on ack_i.
    - NMI ack: clear nmi_pend, set nmi_active.
    - Maskable ack: clear pending[id], set in_service[id].
- **Vector:** VEC_BASE + id*VEC_STRIDE, computed in VEC_W bits, wrap modulo 2^VEC_W. NMI uses NMI_VEC.
- **eret_i:**
  - If nmi_active is set, clear nmi_active only.
  - Otherwise clear the highest-priority in_service bit.
  - With nothing in service, ignored. Accepted in any state.
- ack_i in IDLE is ignored.
- A repeat edge on a line that is pending or in service re-sets its pending bit; no counting.

## Timing
- **Reset (async, rst_n = 0):** state IDLE, req_o 0, req_nmi_o 0, vector_o 0, id_o 0, pending_o 0, in_service_o 0, mask_o 0, nmi_pend 0, nmi_active 0, prev_* 0.
  - Reset mid-REQ drops req_o immediately.
  - A line held high through reset release produces no edge.
- **Latency:** edge sampled at clk edge E0 (prev 0, irq 1) → pending set after E0 → req_o high after E1. Minimum 2 cycles from input to request.
- **Handshake:** ack_i is sampled only while req_o = 1. req_o falls the cycle after ack. A new request may assert the following cycle (one IDLE cycle minimum).
- **Mask write:** effective from the next cycle's eligibility evaluation.

## Configuration
- IRQ_NESTING_EN defined: a maskable line is eligible only if its index is lower (higher priority) than every set in_service bit. Higher-priority lines preempt.
- IRQ_NESTING_EN undefined: any set in_service bit, or nmi_active, blocks all maskable requests until eret_i clears it. NMI is unaffected.

## Structure
- **Package mc_irq_pkg:**
  - state enum (IDLE, REQ)
  - default VEC_BASE, VEC_STRIDE and NMI_VEC constants
  - function for the index width
- **Sub-module mc_irq_prio_enc:** parametrised lowest-index-first priority encoder with a valid output. Instantiated twice: once to select the winning eligible line, once to find the highest in-service bit for eret_i and for the nesting compare.

## Test plan
- **Basic request:** reset; mask=8'hFF, gie=1; pulse irq_i[3] → req_o=1 two cycles later, id_o=3, vector_o=32'h10C; ack → pending[3]=0, in_service[3]=1; eret → in_service=0.
- **Priority and freeze:** irq[5] and irq[2] in the same cycle → id_o=2, vector 32'h108. Raise irq[0] during REQ → id stays 2 until ack; irq[0] is presented after the IDLE cycle.
- **NMI:** nmi edge while maskable in service (gie=1) → req_nmi_o=1, vector_o=32'h80. A second nmi edge before eret is held pending, then presented after eret.
- **Masking:** mask=0, edge on irq[1] → pending[1]=1, no req. Write mask bit 1 → req the next cycle.
- **Nesting:** in_service[4] set, edge on irq[1] → req only when IRQ_NESTING_EN is defined. Edge on irq[6] → no req in either build.
- **Reset mid-REQ:** assert rst_n=0 while req_o=1 → all outputs 0 immediately. irq held high across release → no request.

Source files
------------

// File: rtl/mc_irq_pkg.sv
// Shared types and defaults for the mc_irq_ctrl interrupt controller.
// Holds the request FSM state type, default vector layout and the index-width helper.
package mc_irq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam int          DEF_VEC_STRIDE = 4;
  localparam logic [31:0] DEF_NMI_VEC    = 32'h0000_0080;

  // A single line still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_irq_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
// Used both for picking the winning request and for locating the highest-priority in-service line.
module mc_irq_prio_enc
  import mc_irq_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mc_irq_ctrl.sv
// Interrupt controller: edge-latched maskable lines with fixed priority, one NMI, vectoring and in-service tracking.
// Build option IRQ_NESTING_EN: higher-priority maskable lines may preempt in-service ones.
//   state   | meaning
//   ST_IDLE | no request presented; winner captured when anything is eligible
//   ST_REQ  | req_o high, outputs frozen until ack_i
module mc_irq_ctrl
  import mc_irq_pkg::*;
#(
  parameter int               NUM_IRQ    = 8,
  parameter int               VEC_W      = 32,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(DEF_VEC_BASE),
  parameter int               VEC_STRIDE = DEF_VEC_STRIDE,
  parameter logic [VEC_W-1:0] NMI_VEC    = VEC_W'(DEF_NMI_VEC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_IRQ-1:0]          irq_i,
  input  logic                        nmi_i,
  input  logic                        gie_i,
  input  logic                        mask_we_i,
  input  logic [NUM_IRQ-1:0]          mask_wdata_i,
  output logic                        req_o,
  output logic                        req_nmi_o,
  output logic [VEC_W-1:0]            vector_o,
  output logic [idx_w(NUM_IRQ)-1:0]   id_o,
  input  logic                        ack_i,
  input  logic                        eret_i,
  output logic [NUM_IRQ-1:0]          pending_o,
  output logic [NUM_IRQ-1:0]          in_service_o,
  output logic [NUM_IRQ-1:0]          mask_o
);

  localparam int IW = idx_w(NUM_IRQ);

  irq_state_e         state_q;
  logic               req_q, req_nmi_q;
  logic [IW-1:0]      id_q;
  logic [VEC_W-1:0]   vector_q;

  logic [NUM_IRQ-1:0] prev_irq_q, pending_q, in_service_q, mask_q;
  logic [NUM_IRQ-1:0] pending_d, in_service_d;
  logic               prev_nmi_q, nmi_pend_q, nmi_active_q, armed_q;
  logic               nmi_pend_d, nmi_active_d;

  logic [NUM_IRQ-1:0] irq_rise, allow, elig, ack_clr, eret_clr;
  logic               nmi_rise, nmi_elig, ack_fire, ack_nmi, eret_nmi;
  logic               win_valid, isr_valid;
  logic [IW-1:0]      win_idx, isr_idx;
  logic [VEC_W-1:0]   win_vec;

  // armed_q masks the first sample after reset so a line held high through release is not an edge.
  assign irq_rise = armed_q ? (irq_i & ~prev_irq_q) : '0;
  assign nmi_rise = armed_q & nmi_i & ~prev_nmi_q;

  assign ack_fire = (state_q == ST_REQ) && ack_i;
  assign ack_nmi  = ack_fire && req_nmi_q;
  assign eret_nmi = eret_i && nmi_active_q;

  mc_irq_prio_enc #(.N(NUM_IRQ), .IW(IW)) u_isr_enc (
    .req_i   (in_service_q),
    .valid_o (isr_valid),
    .idx_o   (isr_idx)
  );

  always_comb begin
    allow = '1;
`ifdef IRQ_NESTING_EN
    for (int i = 0; i < NUM_IRQ; i++) begin
      allow[i] = !isr_valid || (IW'(i) < isr_idx);
    end
`else
    if (isr_valid || nmi_active_q) allow = '0;
`endif
  end

  assign elig     = pending_q & mask_q & {NUM_IRQ{gie_i}} & allow;
  assign nmi_elig = nmi_pend_q & ~nmi_active_q;

  mc_irq_prio_enc #(.N(NUM_IRQ), .IW(IW)) u_win_enc (
    .req_i   (elig),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  assign win_vec = VEC_BASE + (VEC_W'(win_idx) * VEC_W'(VEC_STRIDE));

  always_comb begin
    ack_clr  = '0;
    eret_clr = '0;
    if (ack_fire && !req_nmi_q) ack_clr[id_q] = 1'b1;
    if (eret_i && !nmi_active_q && isr_valid) eret_clr[isr_idx] = 1'b1;
  end

  // Sets are OR-ed in after clears so a same-cycle set always wins.
  assign pending_d    = (pending_q & ~ack_clr) | irq_rise;
  assign in_service_d = (in_service_q & ~eret_clr) | ack_clr;
  assign nmi_pend_d   = (nmi_pend_q & ~ack_nmi) | nmi_rise;
  assign nmi_active_d = (nmi_active_q & ~eret_nmi) | ack_nmi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_irq_q   <= '0;
      prev_nmi_q   <= 1'b0;
      armed_q      <= 1'b0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
      nmi_pend_q   <= 1'b0;
      nmi_active_q <= 1'b0;
    end else begin
      prev_irq_q   <= irq_i;
      prev_nmi_q   <= nmi_i;
      armed_q      <= 1'b1;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      nmi_pend_q   <= nmi_pend_d;
      nmi_active_q <= nmi_active_d;
      if (mask_we_i) mask_q <= mask_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      req_nmi_q <= 1'b0;
      id_q      <= '0;
      vector_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (nmi_elig || win_valid) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            if (nmi_elig) begin
              req_nmi_q <= 1'b1;
              id_q      <= '0;
              vector_q  <= NMI_VEC;
            end else begin
              req_nmi_q <= 1'b0;
              id_q      <= win_idx;
              vector_q  <= win_vec;
            end
          end
        end
        ST_REQ: begin
          if (ack_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_o        = req_q;
  assign req_nmi_o    = req_nmi_q;
  assign id_o         = id_q;
  assign vector_o     = vector_q;
  assign pending_o    = pending_q;
  assign in_service_o = in_service_q;
  assign mask_o       = mask_q;

endmodule
